// File: rtl/alu_op_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// One command in flight; result returned on a tagged valid/ready response channel.
module alu_op_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1,
  parameter int NUM_OPS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_opsel,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             last_grant;
  logic             grant_id;
  logic [3:0]       cnt;

  logic             gnt_vld;
  logic             gnt_sel;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;

  function automatic logic op_illegal(input logic [2:0] op);
    return int'({29'd0, op}) >= NUM_OPS;
  endfunction

  // Grant: a lone requester wins outright; a tie goes to whoever did not win last.
  always_comb begin
    gnt_vld = req0_valid | req1_valid;
    gnt_sel = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    op_sel  = gnt_sel ? req1_op : req0_op;
    a_sel   = gnt_sel ? req1_a  : req0_a;
    b_sel   = gnt_sel ? req1_b  : req0_b;
  end

  assign req0_ready = (state == IDLE) & gnt_vld & ~gnt_sel;
  assign req1_ready = (state == IDLE) & gnt_vld &  gnt_sel;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opsel  <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            grant_id   <= gnt_sel;
            last_grant <= gnt_sel;
            // Illegal opcodes bypass the ALU so its inputs keep their last values.
            if (op_illegal(op_sel)) begin
              rsp_valid  <= 1'b1;
              rsp_id     <= gnt_sel;
              rsp_result <= '0;
              rsp_err    <= 1'b1;
              state      <= RESP;
            end else begin
              alu_a     <= a_sel;
              alu_b     <= b_sel;
              alu_opsel <= op_sel;
              cnt       <= 4'(ALU_LAT - 1);
              state     <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= grant_id;
            rsp_result <= alu_result;
            rsp_err    <= 1'b0;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_op_arbiter.md
Name: alu_op_arbiter

Overview:
- Shares one combinational 32-bit ALU between two requesters. The ALU's result stage is the 8-to-1 mux selected by the 3-bit opsel.
- Round-robin arbitration on a valid/ready request handshake.
- Latches operands and opcode, then drives the ALU for a fixed latency and captures the result.
- Returns the result on a single valid/ready response channel tagged with the requester ID.
- Sits between the processor's issue logic (or a debug port) and the ALU datapath.

Parameters:
- WIDTH, 32, operand/result width.
- ALU_LAT, 1, cycles the ALU is driven before the result is captured (legal range 1..15).
- NUM_OPS, 8, number of legal opcodes; opcode >= NUM_OPS is illegal.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a command.
- req0_ready  output  1  requester 0 command accepted this cycle.
- req0_op  input  3  requester 0 opcode (ALU opsel).
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer takes the response.
- rsp_id  output  1  requester that owns the response.
- rsp_result  output  WIDTH  captured ALU result.
- rsp_err  output  1  illegal opcode; rsp_result is 0.
- alu_a  output  WIDTH  ALU operand A.
- alu_b  output  WIDTH  ALU operand B.
- alu_opsel  output  3  ALU result-mux select.
- alu_result  input  WIDTH  ALU output.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; every output 0; cycle counter 0; last_grant=1, so requester 0 wins first.
- rst overrides any state, including mid-EXEC or mid-RESP. An in-flight command is discarded and no response is issued.
- FSM states: IDLE, EXEC, RESP.

IDLE:
- If any reqN_valid, grant one requester.
  - Only one valid: grant it.
  - Both valid: grant !last_grant.
- reqN_ready is combinational and high only in IDLE, only for the granted requester. At most one ready is high per cycle.
- At the accepting edge:
  - latch op/a/b into internal registers;
  - grant_id <= N, last_grant <= N.
- Legal op -> EXEC; counter <= ALU_LAT-1.
- Illegal op (op >= NUM_OPS) -> RESP directly with err=1 and result 0. The ALU is not driven.

EXEC:
- alu_a, alu_b and alu_opsel are driven from the latched registers, registered and stable for the whole state.
- Counter decrements each cycle.
- At the edge where counter==0: capture alu_result into the result register, go to RESP.

RESP:
- rsp_valid=1; rsp_id, rsp_result and rsp_err are held stable until rsp_ready.
- At the edge where rsp_valid && rsp_ready: go to IDLE.
- New requests are not accepted in RESP. reqN_ready=0 in EXEC and RESP: one command in flight.

General rules:
- alu_* outputs hold their last values outside EXEC. They are cleared only by reset.
- Latency for a legal op accepted at edge T:
  - rsp_valid is first high in cycle T+ALU_LAT+1;
  - the earliest next accept is the cycle after the rsp handshake.
  - With ALU_LAT=1 and rsp_ready tied high, throughput is one op per 3 cycles.
- Illegal op: rsp_valid is high in cycle T+1.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1.
- A request whose valid drops before it is granted is simply not served. Requesters must hold op/a/b stable while valid and not ready.

Test Plan:
- Reset, then req0 only: op=3'b001, a=32'h0000_000F, b=32'h0000_0001 -> req0_ready for 1 cycle; alu_opsel=001, alu_a=0xF in EXEC; 2 cycles after accept rsp_valid=1, rsp_id=0, rsp_err=0, rsp_result=model(001,0xF,0x1).
- req0 and req1 valid every cycle, rsp_ready=1, 6 commands -> grant order 0,1,0,1,0,1; each rsp_id matches the grant; never both readies high.
- NUM_OPS=6, req1 op=3'b111 -> accepted; rsp_valid next cycle with rsp_err=1, rsp_result=0; alu_opsel unchanged from the previous op.
- ALU_LAT=3, rsp_ready held 0 for 5 cycles after rsp_valid -> rsp_valid asserted 4 cycles after accept; rsp_result/rsp_id held stable through the stall; no request accepted until the cycle after rsp_ready=1.
- rst=1 asserted in EXEC (and separately in RESP) -> next cycle busy=0, rsp_valid=0, all outputs 0; the first post-reset request from req1 alone is granted; with both valid, req0 is granted.
- ALU swept through all 8 opsel values, including 3'b000 and 3'b111, with a=32'hFFFF_FFFF, b=32'h0000_0001 -> each rsp_result equals alu_result sampled on the capture edge.
